// File: rtl/riscv_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_decode_pkg
// Brief  : RV32I opcode, branch funct3, branch-mask index and immediate-format
//          definitions shared by the decode stage.
// Rev    : 1.0  initial release
// ============================================================================
package riscv_decode_pkg;

  // Opcodes as instr[6:2]; instr[1:0] is the 2'b11 length field.
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  localparam logic [2:0] FUNC_BEQ  = 3'b000;
  localparam logic [2:0] FUNC_BNE  = 3'b001;
  localparam logic [2:0] FUNC_BLT  = 3'b100;
  localparam logic [2:0] FUNC_BGE  = 3'b101;
  localparam logic [2:0] FUNC_BLTU = 3'b110;
  localparam logic [2:0] FUNC_BGEU = 3'b111;

  localparam int BM_BEQ  = 0;
  localparam int BM_BNE  = 1;
  localparam int BM_BLT  = 2;
  localparam int BM_BGE  = 3;
  localparam int BM_BLTU = 4;
  localparam int BM_BGEU = 5;
  localparam int BM_W    = 6;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [4:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OPC_LUI, OPC_AUIPC: fmt = IMM_U;
      OPC_JAL:            fmt = IMM_J;
      OPC_BRANCH:         fmt = IMM_B;
      OPC_STORE:          fmt = IMM_S;
      OPC_OP:             fmt = IMM_R;
      default:            fmt = IMM_I;
    endcase
    return fmt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_fifo.sv
`default_nettype none
// ============================================================================
// Module : decode_fifo
// Brief  : DEPTH x WIDTH register queue with occupancy count and flush.
// Rev    : 1.0  initial release
// ============================================================================
module decode_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_push,
  input  logic             I_pop,
  input  logic             I_flush,
  input  logic [WIDTH-1:0] I_data,
  output logic [WIDTH-1:0] O_data,
  output logic [CNT_W-1:0] O_count,
  output logic             O_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = I_push & ~I_flush;
  assign w_pop   = I_pop & ~I_flush & (r_count != '0);
  assign O_data  = r_mem[r_rptr];
  assign O_count = r_count;
  assign O_full  = (r_count == CNT_W'(DEPTH));

  // Storage is cleared on reset so the head reads zero straight after reset.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= I_data;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (I_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module : decode_stage
// Brief  : RV32I decoder feeding a DEPTH-entry queue between fetch and execute.
//          Illegal-instruction flagging is built when DECODE_STAGE_ILLEGAL_EN
//          is defined.
// Rev    : 1.0  initial release
// ============================================================================
module decode_stage
  import riscv_decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic                     I_valid,
  output logic                     O_ready,
  input  logic [31:0]              I_instr,
  input  logic [PC_W-1:0]          I_pc,
  input  logic                     I_flush,
  output logic [4:0]               O_rf_rs1,
  output logic [4:0]               O_rf_rs2,
  output logic                     O_valid,
  input  logic                     I_ready,
  output logic [PC_W-1:0]          O_pc,
  output logic [4:0]               O_rs1,
  output logic [4:0]               O_rs2,
  output logic [4:0]               O_rd,
  output logic [4:0]               O_opcode,
  output logic [2:0]               O_funct3,
  output logic [6:0]               O_funct7,
  output logic [31:0]              O_imm,
  output logic [5:0]               O_branchmask,
  output logic                     O_illegal,
  output logic [$clog2(DEPTH):0]   O_count
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BASE_W = PC_W + 5 + 5 + 5 + 5 + 3 + 7 + 32 + BM_W;
`ifdef DECODE_STAGE_ILLEGAL_EN
  localparam int ENTRY_W = BASE_W + 1;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  logic [4:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic [31:0]       w_imm;
  logic [BM_W-1:0]   w_bmask;
  imm_fmt_e          w_fmt;
  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_opcode = I_instr[6:2];
  assign w_funct3 = I_instr[14:12];
  assign w_fmt    = imm_fmt(w_opcode);
  assign O_rf_rs1 = I_instr[19:15];
  assign O_rf_rs2 = I_instr[24:20];

  always_comb begin
    w_imm = {{20{I_instr[31]}}, I_instr[31:20]};
    case (w_fmt)
      IMM_S: w_imm = {{20{I_instr[31]}}, I_instr[31:25], I_instr[11:7]};
      IMM_B: w_imm = {{19{I_instr[31]}}, I_instr[31], I_instr[7],
                      I_instr[30:25], I_instr[11:8], 1'b0};
      IMM_U: w_imm = {I_instr[31:12], 12'b0};
      IMM_J: w_imm = {{11{I_instr[31]}}, I_instr[31], I_instr[19:12],
                      I_instr[20], I_instr[30:21], 1'b0};
      default: w_imm = {{20{I_instr[31]}}, I_instr[31:20]};
    endcase
  end

  // funct3 010/011 on a branch are reserved and leave the mask empty.
  always_comb begin
    w_bmask = '0;
    if (w_opcode == OPC_BRANCH) begin
      case (w_funct3)
        FUNC_BEQ:  w_bmask[BM_BEQ]  = 1'b1;
        FUNC_BNE:  w_bmask[BM_BNE]  = 1'b1;
        FUNC_BLT:  w_bmask[BM_BLT]  = 1'b1;
        FUNC_BGE:  w_bmask[BM_BGE]  = 1'b1;
        FUNC_BLTU: w_bmask[BM_BLTU] = 1'b1;
        FUNC_BGEU: w_bmask[BM_BGEU] = 1'b1;
        default:   w_bmask = '0;
      endcase
    end
  end

  assign w_entry[BASE_W-1:0] = {I_pc, I_instr[19:15], I_instr[24:20],
                                I_instr[11:7], w_opcode, w_funct3,
                                I_instr[31:25], w_imm, w_bmask};

`ifdef DECODE_STAGE_ILLEGAL_EN
  logic w_illegal;
  always_comb begin
    w_illegal = (I_instr[1:0] != 2'b11);
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: ;
      OPC_BRANCH:
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) w_illegal = 1'b1;
      OPC_OP:
        if (I_instr[31:25] != 7'b0000000 && I_instr[31:25] != 7'b0100000)
          w_illegal = 1'b1;
      default: w_illegal = 1'b1;
    endcase
  end
  assign w_entry[BASE_W] = w_illegal;
  assign O_illegal       = w_head[BASE_W];
`else
  assign O_illegal = 1'b0;
`endif

  // A full queue still accepts when the head leaves in the same cycle.
  assign O_ready = ~w_full | I_ready;
  assign O_valid = (w_count != '0);
  assign w_push  = I_valid & O_ready & ~I_flush;
  assign w_pop   = O_valid & I_ready & ~I_flush;
  assign O_count = w_count;

  decode_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_push  (w_push),
    .I_pop   (w_pop),
    .I_flush (I_flush),
    .I_data  (w_entry),
    .O_data  (w_head),
    .O_count (w_count),
    .O_full  (w_full)
  );

  assign {O_pc, O_rs1, O_rs2, O_rd, O_opcode, O_funct3, O_funct7,
          O_imm, O_branchmask} = w_head[BASE_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_decode_stage
// Brief  : Self-checking bench for decode_stage: directed vectors, corner
//          sequences and randomized traffic against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

  localparam int DEPTH = 2;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef DECODE_STAGE_ILLEGAL_EN
  localparam bit EXP_ILL_ZERO = 1'b1;
`else
  localparam bit EXP_ILL_ZERO = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_valid, i_ready, i_flush;
  logic [31:0]      i_instr;
  logic [PC_W-1:0]  i_pc;
  logic             o_ready, o_valid, o_illegal;
  logic [4:0]       o_rf_rs1, o_rf_rs2, o_rs1, o_rs2, o_rd, o_opcode;
  logic [2:0]       o_funct3;
  logic [6:0]       o_funct7;
  logic [31:0]      o_imm;
  logic [5:0]       o_bmask;
  logic [PC_W-1:0]  o_pc;
  logic [CNT_W-1:0] o_count;

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(i_valid), .O_ready(o_ready),
    .I_instr(i_instr), .I_pc(i_pc), .I_flush(i_flush),
    .O_rf_rs1(o_rf_rs1), .O_rf_rs2(o_rf_rs2), .O_valid(o_valid),
    .I_ready(i_ready), .O_pc(o_pc), .O_rs1(o_rs1), .O_rs2(o_rs2),
    .O_rd(o_rd), .O_opcode(o_opcode), .O_funct3(o_funct3),
    .O_funct7(o_funct7), .O_imm(o_imm), .O_branchmask(o_bmask),
    .O_illegal(o_illegal), .O_count(o_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd, opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  mask;
    logic        ill;
  } head_t;

  typedef struct {
    logic [31:0] instr, pc, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [5:0]  mask;
  } vec_t;

  head_t q[$];
  int checks = 0;
  int failures = 0;
  logic [4:0] legal_ops [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001,
                                 5'b11000, 5'b00000, 5'b01000, 5'b00100,
                                 5'b01100, 5'b00011, 5'b11100};

  // Reference decode from the instruction-set rules, using shift/sign arithmetic.
  function automatic head_t model(input logic [31:0] i, input logic [31:0] pc);
    head_t h;
    logic [31:0] v;
    int idx [8] = '{0, 1, -1, -1, 2, 3, 4, 5};
    bit op_ok;
    h.pc = pc; h.rs1 = i[19:15]; h.rs2 = i[24:20]; h.rd = i[11:7];
    h.opcode = i[6:2]; h.funct3 = i[14:12]; h.funct7 = i[31:25];
    case (h.opcode)
      5'b01101, 5'b00101: h.imm = i & 32'hFFFF_F000;
      5'b11011: begin
        v = (((i >> 31) & 1) << 20) | (((i >> 12) & 32'hFF) << 12) |
            (((i >> 20) & 1) << 11) | (((i >> 21) & 32'h3FF) << 1);
        h.imm = $signed(v << 11) >>> 11;
      end
      5'b11000: begin
        v = (((i >> 31) & 1) << 12) | (((i >> 7) & 1) << 11) |
            (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
        h.imm = $signed(v << 19) >>> 19;
      end
      5'b01000: begin
        v = ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
        h.imm = $signed(v << 20) >>> 20;
      end
      default: h.imm = $signed(i) >>> 20;
    endcase
    h.mask = '0;
    if (h.opcode == 5'b11000 && idx[h.funct3] >= 0) h.mask = 6'(1 << idx[h.funct3]);
    op_ok = 1'b0;
    foreach (legal_ops[k]) if (legal_ops[k] == h.opcode) op_ok = 1'b1;
    h.ill = (i[1:0] != 2'b11) || !op_ok ||
            (h.opcode == 5'b11000 && (h.funct3 == 3'b010 || h.funct3 == 3'b011)) ||
            (h.opcode == 5'b01100 && h.funct7 != 7'h00 && h.funct7 != 7'h20);
`ifndef DECODE_STAGE_ILLEGAL_EN
    h.ill = 1'b0;
`endif
    return h;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check head/count at the falling edge, drive inputs, check the
  // combinational outputs, then advance the model to match the next rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    head_t act;
    bit exp_ready, push, pop;
    @(negedge clk);
    cmp("count", o_count, q.size());
    cmp("valid", o_valid, q.size() != 0);
    if (q.size() != 0) begin
      act = {o_pc, o_rs1, o_rs2, o_rd, o_opcode, o_funct3, o_funct7, o_imm, o_bmask, o_illegal};
      cmp("head", act, q[0]);
    end
    i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
    #1;
    cmp("rf_rs1", o_rf_rs1, ins[19:15]);
    cmp("rf_rs2", o_rf_rs2, ins[24:20]);
    exp_ready = (q.size() < DEPTH) || rdy;
    cmp("ready", o_ready, exp_ready);
    push = v && exp_ready && !fl;
    pop  = (q.size() != 0) && rdy && !fl;
    if (fl) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(model(ins, pc));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      r[1:0] = 2'b11;
      r[6:2] = legal_ops[$urandom_range(0, 10)];
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [8];
    tbl[0] = '{32'h00208463, 32'h100, 32'h00000008, 5'd8,  5'd1, 5'd2,  3'd0, 6'b000001};
    tbl[1] = '{32'h00209463, 32'h104, 32'h00000008, 5'd8,  5'd1, 5'd2,  3'd1, 6'b000010};
    tbl[2] = '{32'h0020C463, 32'h108, 32'h00000008, 5'd8,  5'd1, 5'd2,  3'd4, 6'b000100};
    tbl[3] = '{32'h0020A463, 32'h10C, 32'h00000008, 5'd8,  5'd1, 5'd2,  3'd2, 6'b000000};
    tbl[4] = '{32'h123452B7, 32'h110, 32'h12345000, 5'd5,  5'd8, 5'd3,  3'd5, 6'b000000};
    tbl[5] = '{32'hFFDFF0EF, 32'h114, 32'hFFFFFFFC, 5'd1,  5'd31, 5'd29, 3'd7, 6'b000000};
    tbl[6] = '{32'hFE20AC23, 32'h118, 32'hFFFFFFF8, 5'd24, 5'd1, 5'd2,  3'd2, 6'b000000};
    tbl[7] = '{32'hFFF00193, 32'h11C, 32'hFFFFFFFF, 5'd3,  5'd0, 5'd31, 3'd0, 6'b000000};

    rst_n = 1'b0; i_valid = 0; i_ready = 0; i_flush = 0; i_instr = 0; i_pc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    step(0, 0, 0, 0, 0);
    cmp("rst_imm", o_imm, 0);
    cmp("rst_pc", o_pc, 0);
    cmp("rst_bmask", o_bmask, 0);
    cmp("rst_rd", o_rd, 0);
    cmp("rst_ready", o_ready, 1);

    for (int k = 0; k < 8; k++) begin
      step(1, tbl[k].instr, tbl[k].pc, 1, 0);
      step(0, 0, 0, 1, 0);
      cmp($sformatf("tbl%0d_valid", k), o_valid, 1);
      cmp($sformatf("tbl%0d_imm", k), o_imm, tbl[k].imm);
      cmp($sformatf("tbl%0d_rd", k), o_rd, tbl[k].rd);
      cmp($sformatf("tbl%0d_rs1", k), o_rs1, tbl[k].rs1);
      cmp($sformatf("tbl%0d_rs2", k), o_rs2, tbl[k].rs2);
      cmp($sformatf("tbl%0d_f3", k), o_funct3, tbl[k].f3);
      cmp($sformatf("tbl%0d_mask", k), o_bmask, tbl[k].mask);
      cmp($sformatf("tbl%0d_pc", k), o_pc, tbl[k].pc);
    end
    step(0, 0, 0, 1, 0);

    // Back-to-back with execute always ready.
    step(1, 32'h123452B7, 32'h200, 1, 0);
    step(1, 32'hFFDFF0EF, 32'h204, 1, 0);
    cmp("b2b0_imm", o_imm, 32'h12345000);
    cmp("b2b0_rd", o_rd, 5);
    step(1, 32'hFE20AC23, 32'h208, 1, 0);
    cmp("b2b1_imm", o_imm, 32'hFFFFFFFC);
    cmp("b2b1_rd", o_rd, 1);
    step(0, 0, 0, 1, 0);
    cmp("b2b2_imm", o_imm, 32'hFFFFFFF8);
    cmp("b2b2_f3", o_funct3, 3'b010);
    step(0, 0, 0, 1, 0);

    // Backpressure: third push waits until a pop frees a slot in-cycle.
    step(1, 32'h00100093, 32'h300, 0, 0);
    step(1, 32'h00200113, 32'h304, 0, 0);
    step(1, 32'h00300193, 32'h308, 0, 0);
    cmp("bp_count_full", o_count, 2);
    cmp("bp_ready_low", o_ready, 0);
    step(1, 32'h00300193, 32'h308, 1, 0);
    cmp("bp_ready_pop", o_ready, 1);
    step(0, 0, 0, 0, 0);
    cmp("bp_count_stay", o_count, 2);
    cmp("bp_head_pc", o_pc, 32'h304);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    cmp("bp_last_pc", o_pc, 32'h308);
    step(0, 0, 0, 1, 0);

    // Flush with a same-cycle push.
    step(1, 32'h00100093, 32'h400, 0, 0);
    step(1, 32'h00200113, 32'h404, 0, 0);
    step(1, 32'h00500293, 32'h408, 1, 1);
    step(0, 0, 0, 1, 0);
    cmp("flush_count", o_count, 0);
    cmp("flush_valid", o_valid, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // All-zero word: only flagged when illegal detection is built.
    step(1, 32'h00000000, 32'h500, 1, 0);
    step(0, 0, 0, 1, 0);
    cmp("ill_zero", o_illegal, EXP_ILL_ZERO);
    step(0, 0, 0, 1, 0);

    // Asynchronous reset with two entries queued.
    step(1, 32'h00100093, 32'h600, 0, 0);
    step(1, 32'h00200113, 32'h604, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    cmp("arst_valid", o_valid, 0);
    cmp("arst_count", o_count, 0);
    cmp("arst_imm", o_imm, 0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
    end
    repeat (DEPTH + 2) step(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
